// File: rtl/lighthouse_pkg.sv
// Shared definitions for the lighthouse emulator and the receive-side decoder:
// register map, read default, FSM states and sync-code bit positions.
package lighthouse_pkg;

    // Avalon register word indices
    localparam logic [5:0] ADDR_CTRL   = 6'd0;
    localparam logic [5:0] ADDR_SWEEP0 = 6'd1;
    localparam logic [5:0] ADDR_SWEEP1 = 6'd2;
    localparam logic [5:0] ADDR_OOTX   = 6'd3;
    localparam logic [5:0] ADDR_STATUS = 6'd4;

    // Value returned for any unmapped address
    localparam logic [31:0] READ_DEFAULT = 32'hDEAD_BEEF;

    // Register field positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_SKIP_BIT   = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    // Sync code {skip, data, axis} bit positions
    localparam int CODE_SKIP_BIT = 2;
    localparam int CODE_DATA_BIT = 1;
    localparam int CODE_AXIS_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_GAP   = 3'd2,
        ST_SWEEP = 3'd3,
        ST_TAIL  = 3'd4
    } lh_state_e;

    // Sync pulse width in ticks for a 3-bit code
    function automatic logic [31:0] sync_width(input logic [2:0]  code,
                                               input logic [31:0] base,
                                               input logic [31:0] step);
        return base + ({29'd0, code} * step);
    endfunction

endpackage

// File: rtl/ootx_serializer.sv
// Holds the OOTX data word and walks through it MSB first, one bit per frame.
// A new word restarts the walk at bit 31.
module ootx_serializer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_advance,
    output logic [31:0] o_word,
    output logic        o_bit,
    output logic        o_bit_next
);

    logic [31:0] r_word;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_next;

    // Word load restarts the index; otherwise step once per frame end (5-bit wrap)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_advance) begin
            r_idx  <= r_idx + 5'd1;
        end
    end

    assign w_idx_next = r_idx + 5'd1;
    assign o_word     = r_word;
    // o_bit_next is the bit the next frame will carry when this edge also advances
    assign o_bit      = r_word[5'd31 - r_idx];
    assign o_bit_next = r_word[5'd31 - w_idx_next];

endmodule

// File: rtl/lighthouse_emulator.sv
// Lighthouse base-station emulator: one sync flash plus one sweep pulse per
// frame on sensor_signal_o, programmed through a small Avalon-MM register set.
module lighthouse_emulator
    import lighthouse_pkg::*;
#(
    parameter int FRAME_TICKS = 416667,
    parameter int SYNC_BASE   = 3125,
    parameter int SYNC_STEP   = 521,
    parameter int SWEEP_WIDTH = 500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [5:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        sensor_signal_o
);

    localparam logic [31:0] LP_LAST = 32'(FRAME_TICKS - 1);
    localparam logic [31:0] LP_SWW  = 32'(SWEEP_WIDTH);

    // Register file
    logic        r_enable;
    logic        r_skip;
    logic [31:0] r_sweep0;
    logic [31:0] r_sweep1;
    logic        r_sweep_err;
    logic [15:0] r_frame_count;

    // Frame state
    lh_state_e   r_state;
    lh_state_e   w_state_nxt;
    logic [31:0] r_tick;
    logic        r_axis;
    logic [2:0]  r_sh_code;
    logic [31:0] r_sh_sweep;
    logic        r_sensor;

    logic        w_wr_ctrl, w_wr_sw0, w_wr_sw1, w_wr_ootx, w_wr_status;
    logic [31:0] w_ootx_word;
    logic        w_ootx_bit, w_ootx_bit_next;
    logic        w_frame_end;
    logic        w_sync_entry;
    logic        w_axis_next;
    logic [2:0]  w_code_next;
    logic [31:0] w_sync_width;
    logic        w_sweep_bad;
    logic        w_busy;
    logic        w_read_unused;

    // Reads have no side effects; the strobe is accepted but not needed
    assign w_read_unused = read;
    assign waitrequest   = 1'b0;

    assign w_wr_ctrl   = write && (address == ADDR_CTRL);
    assign w_wr_sw0    = write && (address == ADDR_SWEEP0);
    assign w_wr_sw1    = write && (address == ADDR_SWEEP1);
    assign w_wr_ootx   = write && (address == ADDR_OOTX);
    assign w_wr_status = write && (address == ADDR_STATUS);

    ootx_serializer u_ootx (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_load     (w_wr_ootx),
        .i_word     (writedata),
        .i_advance  (w_frame_end),
        .o_word     (w_ootx_word),
        .o_bit      (w_ootx_bit),
        .o_bit_next (w_ootx_bit_next)
    );

    assign w_busy       = (r_state != ST_IDLE);
    assign w_frame_end  = w_busy && (r_tick == LP_LAST);
    assign w_sync_entry = r_enable && ((r_state == ST_IDLE) || w_frame_end);
    // At a frame boundary the new frame uses the toggled axis and advanced bit
    assign w_axis_next  = w_frame_end ? ~r_axis : r_axis;

    assign w_sync_width = sync_width(r_sh_code, 32'(SYNC_BASE), 32'(SYNC_STEP));
    // 33-bit compares so a huge programmed sweep tick cannot wrap into range
    assign w_sweep_bad  = ({1'b0, r_sh_sweep} < ({1'b0, w_sync_width} + 33'd1)) ||
                          (({1'b0, r_sh_sweep} + {1'b0, LP_SWW}) > 33'(FRAME_TICKS));

    // Sync code for the frame about to start, from pre-edge register values
    always_comb begin
        w_code_next                = '0;
        w_code_next[CODE_SKIP_BIT] = r_skip;
        w_code_next[CODE_DATA_BIT] = w_frame_end ? w_ootx_bit_next : w_ootx_bit;
        w_code_next[CODE_AXIS_BIT] = w_axis_next;
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; the frame boundary overrides whatever phase is active
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_enable) w_state_nxt = ST_SYNC;
            ST_SYNC:  if (r_tick == w_sync_width - 32'd1) w_state_nxt = ST_GAP;
            ST_GAP: begin
                if (r_sh_code[CODE_SKIP_BIT] || w_sweep_bad)
                    w_state_nxt = ST_TAIL;
                else if (r_tick + 32'd1 == r_sh_sweep)
                    w_state_nxt = ST_SWEEP;
            end
            ST_SWEEP: if (r_tick == r_sh_sweep + LP_SWW - 32'd1) w_state_nxt = ST_TAIL;
            ST_TAIL:  ;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_frame_end) w_state_nxt = r_enable ? ST_SYNC : ST_IDLE;
    end

    // Frame tick, axis, per-frame shadows and the registered light output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick        <= '0;
            r_axis        <= 1'b0;
            r_sh_code     <= '0;
            r_sh_sweep    <= '0;
            r_frame_count <= '0;
            r_sensor      <= 1'b0;
        end else begin
            r_tick   <= (w_frame_end || !w_busy) ? 32'd0 : r_tick + 32'd1;
            r_sensor <= (w_state_nxt == ST_SYNC) || (w_state_nxt == ST_SWEEP);
            if (w_frame_end) begin
                r_axis        <= ~r_axis;
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_sync_entry) begin
                r_sh_code  <= w_code_next;
                r_sh_sweep <= w_axis_next ? r_sweep1 : r_sweep0;
            end
        end
    end

    assign sensor_signal_o = r_sensor;

    // Software-visible registers; a detected bad sweep wins over a same-edge clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_skip      <= 1'b0;
            r_sweep0    <= '0;
            r_sweep1    <= '0;
            r_sweep_err <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= writedata[CTRL_ENABLE_BIT];
                r_skip   <= writedata[CTRL_SKIP_BIT];
            end
            if (w_wr_sw0) r_sweep0 <= writedata;
            if (w_wr_sw1) r_sweep1 <= writedata;
            if ((r_state == ST_GAP) && !r_sh_code[CODE_SKIP_BIT] && w_sweep_bad)
                r_sweep_err <= 1'b1;
            else if (w_wr_status && writedata[STATUS_ERR_BIT])
                r_sweep_err <= 1'b0;
        end
    end

    // Combinational readback
    always_comb begin
        readdata = READ_DEFAULT;
        case (address)
            ADDR_CTRL:   readdata = {30'd0, r_skip, r_enable};
            ADDR_SWEEP0: readdata = r_sweep0;
            ADDR_SWEEP1: readdata = r_sweep1;
            ADDR_OOTX:   readdata = w_ootx_word;
            ADDR_STATUS: readdata = {r_frame_count, 14'd0, r_sweep_err, w_busy};
            default:     readdata = READ_DEFAULT;
        endcase
    end

endmodule
